uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of uart_rx. It captures each byte that uart_rx strobes out on its one-cycle valid pulse and stores it in a circular FIFO. It then presents the bytes in order on a ready/valid read port to the consumer (uart_tx loopback or a command parser). It absorbs bursts at 115200 baud and reports lost bytes instead of silently dropping them.

Parameters:
DATA_BITS, 8, width of each stored byte; matches uart_rx DATA_BITS
ADDR_BITS, 4, pointer width; FIFO depth DEPTH = 2**ADDR_BITS (16 by default)

Ports:
clk  input  1  system clock; same divided clock that drives uart_rx
rst  input  1  reset, asynchronous, active-high
wr_valid  input  1  one-cycle write strobe; wired to uart_rx valid_out
wr_data  input  DATA_BITS  byte to store; wired to uart_rx data_out
rd_ready  input  1  consumer can take the head byte this cycle
rd_valid  output  1  head byte available (high whenever FIFO not empty)
rd_data  output  DATA_BITS  head byte (first-word-fall-through)
count  output  ADDR_BITS+1  number of stored bytes, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
overflow  output  1  sticky flag: at least one byte dropped
drop_cnt  output  8  saturating count of dropped bytes
clr_overflow  input  1  one-cycle clear of overflow and drop_cnt

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, drop_cnt=0. Memory contents are not reset. Reset mid-operation discards all stored bytes immediately. No output glitches to non-reset values while rst is high.
- Storage: DEPTH x DATA_BITS array. wr_ptr and rd_ptr are ADDR_BITS wide and wrap modulo DEPTH (DEPTH-1 -> 0). count is held in a separate register; full and empty are decoded from it.
- Push: occurs on a rising edge where wr_valid=1 and the push is accepted. mem[wr_ptr] <= wr_data, then wr_ptr increments.
- Pop: occurs on a rising edge where rd_valid=1 and rd_ready=1. rd_ptr increments.
- Read port (FWFT): rd_valid = !empty. rd_data = mem[rd_ptr] when not empty, and is forced to 0 when empty.
- Latency: a byte pushed into an empty FIFO appears on rd_data with rd_valid=1 in the cycle immediately after the write edge (1 cycle).
- rd_ready while empty has no effect: no pointer move, no underflow.
- Push acceptance rules:
  - Not full: push accepted.
  - Full, with a pop on the same edge: push accepted, so count stays DEPTH and the oldest byte leaves while the new byte enters.
  - Full, with no pop: byte dropped. Pointers and count unchanged, overflow <= 1, drop_cnt increments and saturates at 255.
- Count update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
  - Empty with wr_valid=1 and rd_ready=1: push only, because pop needs rd_valid; count becomes 1.
- Overflow clear: clr_overflow=1 clears overflow and drop_cnt on that edge. If a drop occurs on the same edge, the set wins: overflow=1, drop_cnt=1.
- No combinational path from wr_valid/wr_data to rd_valid/rd_data. rd_ready does not combinationally affect any output.
- wr_valid is assumed to be a single-cycle pulse per byte, as produced by uart_rx. A held-high wr_valid pushes once per cycle; this is legal but not the intended use.

Test Plan:
- Reset then push 0xA5 with rd_ready=0 -> next cycle rd_valid=1, rd_data=0xA5, count=1, empty=0. Assert rst mid-stream -> count=0, rd_valid=0, rd_data=0 with no clock edge needed.
- Push 0x00..0x0F (16 bytes), rd_ready=0 -> full=1, count=16. Then pop all 16 -> rd_data sequence 0x00..0x0F in order, empty=1 after the last pop.
- Full FIFO, push 0x55 with rd_ready=0 -> byte dropped, overflow=1, drop_cnt=1, count=16. Drain -> 0x55 never appears.
- Full FIFO, push 0x77 with rd_ready=1 on the same edge -> count stays 16, head advances, 0x77 emerges as the 16th byte after draining.
- Wrap-around: push/pop 40 bytes 0x10..0x37 with count held between 1 and 3 -> output order matches input exactly across multiple pointer wraps.
- 300 pushes into a full FIFO -> drop_cnt saturates at 255. Pulse clr_overflow together with one more drop -> overflow=1, drop_cnt=1. Pulse clr_overflow alone -> overflow=0, drop_cnt=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind uart_rx: first-word-fall-through read port,
// with overflow tracking for bytes lost while full.
module uart_rx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_ready,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [7:0]           drop_cnt,
  input  logic                 clr_overflow
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 drop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_valid && (!full || pop);
  assign drop = wr_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_BITS'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (ADDR_BITS+1)'(1);
        2'b01:   count <= count - (ADDR_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop on the clearing edge wins, so it is counted as the first loss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_overflow) begin
      overflow <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference
// model; directed scenarios plus a randomized traffic phase.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clr_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  int         m_ov = 0;
  int         m_dc = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DATA_BITS(8), .ADDR_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .wr_valid(wr_valid),
    .wr_data(wr_data),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .count(count),
    .full(full),
    .empty(empty),
    .overflow(overflow),
    .drop_cnt(drop_cnt),
    .clr_overflow(clr_overflow)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    chk({tag, ".rd_data"},  32'(rd_data),  32'(head));
    chk({tag, ".count"},    32'(count),    32'(q.size()));
    chk({tag, ".full"},     32'(full),     32'(q.size() == 16));
    chk({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_dc));
  endtask

  // Reference behaviour for one clock edge, from the pre-edge state.
  task automatic model_edge(bit wv, logic [7:0] wd, bit rr, bit clr);
    bit do_pop, do_push, do_drop;
    do_pop  = (q.size() != 0) && rr;
    do_push = wv && (q.size() < 16 || do_pop);
    do_drop = wv && !do_push;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(wd);
    if (clr) begin
      m_ov = do_drop ? 1 : 0;
      m_dc = do_drop ? 1 : 0;
    end else if (do_drop) begin
      m_ov = 1;
      if (m_dc < 255) m_dc++;
    end
  endtask

  task automatic step(string tag, bit wv, logic [7:0] wd, bit rr, bit clr);
    @(negedge clk);
    wr_valid     = wv;
    wr_data      = wd;
    rd_ready     = rr;
    clr_overflow = clr;
    @(posedge clk);
    model_edge(wv, wd, rr, clr);
    #1;
    check_all(tag);
  endtask

  task automatic drain(string tag);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst          = 1'b1;
    wr_valid     = 1'b0;
    wr_data      = 8'h00;
    rd_ready     = 1'b0;
    clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    step("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_head", 32'(rd_data), 32'h0000_00A5);
    for (int i = 0; i < 5; i++)
      step("pre_rst", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);

    // Reset away from any clock edge must clear outputs immediately.
    #2;
    rst      = 1'b1;
    wr_valid = 1'b0;
    q.delete();
    m_ov = 0;
    m_dc = 0;
    #1;
    check_all("mid_rst");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    drain("drain_seq");
    chk("drain_empty", 32'(empty), 32'd1);

    for (int i = 0; i < 16; i++)
      step("fill2", 1'b1, 8'($urandom_range(0, 84)), 1'b0, 1'b0);
    step("drop55", 1'b1, 8'h55, 1'b0, 1'b0);
    chk("drop55_ov", 32'(overflow), 32'd1);
    chk("drop55_dc", 32'(drop_cnt), 32'd1);
    drain("drain55");

    for (int i = 0; i < 16; i++)
      step("fill3", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step("push77_pop", 1'b1, 8'h77, 1'b1, 1'b0);
    chk("push77_cnt", 32'(count), 32'd16);
    drain("drain77");

    for (int i = 0; i < 40; i++) begin
      bit rr;
      rr = (q.size() >= 2) ? 1'b1 : (q.size() == 0 ? 1'b0 : 1'($urandom_range(0, 1)));
      step("wrap", 1'b1, 8'(8'h10 + i), rr, 1'b0);
      chk("wrap_lo", 32'(count >= 1 && count <= 3), 32'd1);
    end
    drain("wrap_drain");

    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 99) < 60), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3));
    drain("rand_drain");
    step("rand_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 16; i++)
      step("fill4", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++)
      step("sat", 1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    chk("sat_255", 32'(drop_cnt), 32'd255);
    step("clr_drop", 1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_drop_dc", 32'(drop_cnt), 32'd1);
    step("clr_only", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_only_ov", 32'(overflow), 32'd0);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
